// File: rtl/systolic_array_pkg.sv
// Shared types and sizing for the systolic array output path.
// Holds the writeback FSM encoding and the default element/address widths.
package systolic_array_pkg;

    localparam int SA_TILE_DIM   = 2;
    localparam int SA_DATA_WIDTH = 8;
    localparam int SA_ADDR_WIDTH = 16;

    localparam int WB_IDLE_B  = 0;
    localparam int WB_RUN_B   = 1;
    localparam int WB_DRAIN_B = 2;
    localparam int WB_DONE_B  = 3;

    typedef enum logic [3:0] {
        WB_IDLE  = 4'b0001,
        WB_RUN   = 4'b0010,
        WB_DRAIN = 4'b0100,
        WB_DONE  = 4'b1000
    } writeback_state_t;

    localparam int WB_ELEMS = SA_TILE_DIM * SA_TILE_DIM;

    function automatic int wb_elems(input int tile_dim);
        return tile_dim * tile_dim;
    endfunction

endpackage

// File: rtl/acc_bias_saturate.sv
// Adds a sign-extended bias to a double-width accumulator and clamps
// the sum into the signed DATA_WIDTH output range.
module acc_bias_saturate #(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [2*DATA_WIDTH-1:0] acc,
    input  logic signed [DATA_WIDTH-1:0]   bias,
    output logic signed [DATA_WIDTH-1:0]   result
);

    localparam int SUM_W = 2*DATA_WIDTH + 1;

    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-DATA_WIDTH){1'b0}}, OUT_MAX};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-DATA_WIDTH){1'b1}}, OUT_MIN};

    function automatic logic signed [DATA_WIDTH-1:0] sat_clamp(input logic signed [SUM_W-1:0] s);
        if (s > SUM_MAX) begin
            return OUT_MAX;
        end else if (s < SUM_MIN) begin
            return OUT_MIN;
        end else begin
            return s[DATA_WIDTH-1:0];
        end
    endfunction

    logic signed [SUM_W-1:0] sum;

    // One guard bit above the accumulator keeps the add from wrapping.
    assign sum    = {acc[2*DATA_WIDTH-1], acc} + {{(DATA_WIDTH+1){bias[DATA_WIDTH-1]}}, bias};
    assign result = sat_clamp(sum);

endmodule

// File: rtl/sa_tile_writeback.sv
// Tile writeback: walks a finished accumulator tile row-major, reads the
// per-column bias, saturates and writes each in-range element to output RAM.
module sa_tile_writeback
    import systolic_array_pkg::*;
#(
    parameter int TILE_DIM   = SA_TILE_DIM,
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int ADDR_WIDTH = SA_ADDR_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [TILE_DIM*TILE_DIM*2*DATA_WIDTH-1:0] out_tile,
    input  logic [31:0]                           blk_row_idx,
    input  logic [31:0]                           blk_col_idx,
    input  logic [31:0]                           nrows,
    input  logic [31:0]                           ncols,
    input  logic [ADDR_WIDTH-1:0]                 out_base,
    input  logic                                  bias_enable,
    output logic [ADDR_WIDTH-1:0]                 bias_addr,
    output logic                                  bias_en,
    input  logic signed [DATA_WIDTH-1:0]          bias_rdata,
    output logic [ADDR_WIDTH-1:0]                 out_addr,
    output logic                                  out_en,
    output logic signed [DATA_WIDTH-1:0]          out_wdata,
    output logic                                  busy,
    output logic                                  done
);

    localparam int ELEMS = wb_elems(TILE_DIM);
    localparam int ACC_W = 2 * DATA_WIDTH;
    localparam int CNT_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ELEMS - 1);

    writeback_state_t state, state_nxt;
    logic [CNT_W-1:0] elem_cnt;
    logic             run;
    logic             start_ok;

    logic [ELEMS*ACC_W-1:0] tile_q;
    logic [31:0]            blk_row_q, blk_col_q, nrows_q, ncols_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic                   bias_on_q;

    assign run      = state[WB_RUN_B];
    assign start_ok = start && state[WB_IDLE_B];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            WB_IDLE: begin
                if (start) state_nxt = WB_RUN;
            end
            WB_RUN: begin
                busy = 1'b1;
                if (elem_cnt == LAST_CNT) state_nxt = WB_DRAIN;
            end
            WB_DRAIN: begin
                busy      = 1'b1;
                state_nxt = WB_DONE;
            end
            WB_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_cnt <= '0;
        end else if (run && elem_cnt != LAST_CNT) begin
            elem_cnt <= elem_cnt + 1'b1;
        end else begin
            elem_cnt <= '0;
        end
    end

    // Snapshot the tile context so the controller may move on immediately.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            tile_q    <= out_tile;
            blk_row_q <= blk_row_idx;
            blk_col_q <= blk_col_idx;
            nrows_q   <= nrows;
            ncols_q   <= ncols;
            base_q    <= out_base;
            bias_on_q <= bias_enable;
        end
    end

    // ---- stage p0: element coordinates, address and bias read ----
    logic [31:0]             cnt_ext, r_idx, c_idx, gr, gc;
    logic                    vld_p0;
    logic [ADDR_WIDTH-1:0]   addr_p0;
    logic signed [ACC_W-1:0] acc_p0;

    assign cnt_ext = 32'(elem_cnt);
    assign r_idx   = cnt_ext / 32'(TILE_DIM);
    assign c_idx   = cnt_ext % 32'(TILE_DIM);
    assign gr      = blk_row_q * 32'(TILE_DIM) + r_idx;
    assign gc      = blk_col_q * 32'(TILE_DIM) + c_idx;
    assign vld_p0  = run && (gr < nrows_q) && (gc < ncols_q);
    assign addr_p0 = base_q + ADDR_WIDTH'(gr * ncols_q) + ADDR_WIDTH'(gc);
    assign acc_p0  = $signed(tile_q[cnt_ext*ACC_W +: ACC_W]);

    assign bias_en   = vld_p0 && bias_on_q;
    assign bias_addr = bias_en ? ADDR_WIDTH'(gc) : '0;

    // ---- stage p1: bias arrives, add/saturate, write ----
    logic                    vld_p1, bias_on_p1;
    logic [ADDR_WIDTH-1:0]   addr_p1;
    logic signed [ACC_W-1:0] acc_p1;
    logic signed [DATA_WIDTH-1:0] bias_term_p1, sat_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            bias_on_p1 <= 1'b0;
        end else begin
            vld_p1     <= vld_p0;
            bias_on_p1 <= bias_en;
        end
    end

    always_ff @(posedge clk) begin
        acc_p1  <= acc_p0;
        addr_p1 <= addr_p0;
    end

    assign bias_term_p1 = bias_on_p1 ? bias_rdata : '0;

    acc_bias_saturate #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sat (
        .acc   (acc_p1),
        .bias  (bias_term_p1),
        .result(sat_p1)
    );

    assign out_en    = vld_p1;
    assign out_addr  = vld_p1 ? addr_p1 : '0;
    assign out_wdata = vld_p1 ? sat_p1 : '0;

endmodule

// File: tb/tb_sa_tile_writeback.sv
// Directed bench for sa_tile_writeback with a bias RAM model and a write scoreboard.
module tb_sa_tile_writeback;

    localparam int TD   = 2;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int ACCW = 2 * DW;
    localparam int NE   = TD * TD;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [NE*ACCW-1:0]   out_tile;
    logic [31:0]          blk_row_idx, blk_col_idx, nrows, ncols;
    logic [AW-1:0]        out_base;
    logic                 bias_enable;
    logic [AW-1:0]        bias_addr;
    logic                 bias_en;
    logic signed [DW-1:0] bias_rdata = '0;
    logic [AW-1:0]        out_addr;
    logic                 out_en;
    logic signed [DW-1:0] out_wdata;
    logic                 busy;
    logic                 done;

    sa_tile_writeback #(
        .TILE_DIM  (TD),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .out_tile   (out_tile),
        .blk_row_idx(blk_row_idx),
        .blk_col_idx(blk_col_idx),
        .nrows      (nrows),
        .ncols      (ncols),
        .out_base   (out_base),
        .bias_enable(bias_enable),
        .bias_addr  (bias_addr),
        .bias_en    (bias_en),
        .bias_rdata (bias_rdata),
        .out_addr   (out_addr),
        .out_en     (out_en),
        .out_wdata  (out_wdata),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] bias_mem [16];

    always @(posedge clk) begin
        if (bias_en) bias_rdata <= bias_mem[int'(bias_addr) % 16];
    end

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        int            data;
    } wr_t;

    wr_t sb[$];
    int  cmp_cnt = 0;
    int  err_cnt = 0;
    int  cycle   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic cyc();
        wr_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (out_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("wr_cycle", cycle, e.cyc);
                chk("wr_addr", out_addr, e.addr);
                chk("wr_data", $signed(out_wdata), e.data);
            end
        end
    endtask

    task automatic run_tile(input int acc[NE], input int br, input int bc, input int nr,
                            input int nc, input int base, input bit ben, input bit repulse,
                            input int abort_at);
        int  t0, gr, gc, i;
        bit  inr, live, exp_ben;
        t0 = cycle;
        for (int e = 0; e < NE; e++) out_tile[e*ACCW +: ACCW] = ACCW'(acc[e]);
        blk_row_idx = br;
        blk_col_idx = bc;
        nrows       = nr;
        ncols       = nc;
        out_base    = AW'(base);
        bias_enable = ben;
        start       = 1'b1;
        for (int e = 0; e < NE; e++) begin
            gr  = br * TD + e / TD;
            gc  = bc * TD + e % TD;
            inr = (gr < nr) && (gc < nc);
            if (inr && (abort_at < 0 || 2 + e <= abort_at))
                sb.push_back('{t0 + 2 + e, AW'(base + gr * nc + gc),
                               sat8(acc[e] + (ben ? int'(bias_mem[gc]) : 0))});
        end
        chk("busy_c0", busy, 0);
        chk("done_c0", done, 0);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            live = (abort_at < 0) || (k <= abort_at);
            chk("busy", busy, (live && k <= 6) ? 1 : 0);
            chk("done", done, (abort_at < 0 && k == 6) ? 1 : 0);
            if (k >= 1 && k <= NE) begin
                i       = k - 1;
                gr      = br * TD + i / TD;
                gc      = bc * TD + i % TD;
                exp_ben = live && ben && (gr < nr) && (gc < nc);
                chk("bias_en", bias_en, exp_ben ? 1 : 0);
                if (exp_ben) chk("bias_addr", bias_addr, gc);
            end else begin
                chk("bias_en_idle", bias_en, 0);
            end
            if (abort_at >= 0 && k == abort_at + 1) chk("abort_out_en", out_en, 0);
            start = repulse && (k == 2 || k == 6);
            if (k == 1) begin
                out_tile    = ~out_tile;
                out_base    = out_base + 7;
                ncols       = 99;
                bias_enable = !ben;
            end
            if (abort_at >= 0 && k == abort_at) begin
                rst   = 1'b1;
                start = 1'b1;
            end
            if (abort_at >= 0 && k == abort_at + 1) begin
                rst   = 1'b0;
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    int tv[NE];

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        out_tile    = '0;
        blk_row_idx = 0;
        blk_col_idx = 0;
        nrows       = 0;
        ncols       = 0;
        out_base    = '0;
        bias_enable = 1'b0;
        for (int j = 0; j < 16; j++) bias_mem[j] = DW'(j + 20);
        cyc();
        cyc();
        chk("rst_out_en", out_en, 0);
        chk("rst_bias_en", bias_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_wdata", out_wdata, 0);
        chk("rst_bias_addr", bias_addr, 0);
        rst = 1'b0;
        cyc();

        // basic
        bias_mem[0] = 1;
        bias_mem[1] = 2;
        tv = '{10, 20, 30, 40};
        run_tile(tv, 0, 0, 4, 4, 0, 1'b1, 1'b0, -1);

        // saturation
        bias_mem[0] = 5;
        bias_mem[1] = -5;
        tv = '{300, -300, 126, -126};
        run_tile(tv, 0, 0, 4, 4, 8, 1'b1, 1'b0, -1);

        // edge tile: columns 2..3 with ncols=3
        bias_mem[2] = 3;
        bias_mem[3] = 9;
        tv = '{10, 20, 30, 40};
        run_tile(tv, 0, 1, 4, 3, 0, 1'b1, 1'b0, -1);

        // bias off, start re-pulsed mid-tile and in DONE
        tv = '{1, 2, 3, 4};
        run_tile(tv, 1, 0, 4, 4, 100, 1'b0, 1'b1, -1);

        // reset at cycle 3 with start held alongside
        bias_mem[0] = 1;
        bias_mem[1] = 2;
        tv = '{10, 20, 30, 40};
        run_tile(tv, 0, 0, 4, 4, 0, 1'b1, 1'b0, 3);

        // fresh tile after the abort
        tv = '{-7, 50, 0, 100};
        run_tile(tv, 1, 1, 4, 4, 16, 1'b1, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
